// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_pkg
// Brief    : 640x480 timing constants, sync windows and FSM state encoding.
// Revision : 1.0
// ============================================================================
package video_timing_pkg;

    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;

    localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;
    localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    localparam int c_hs_start = c_h_active + c_h_fp;
    localparam int c_hs_end   = c_hs_start + c_h_sync;
    localparam int c_vs_start = c_v_active + c_v_fp;
    localparam int c_vs_end   = c_vs_start + c_v_sync;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/vtg_counter.sv
`default_nettype none
// ============================================================================
// Module   : vtg_counter
// Brief    : Pixel/line position counters with sync, de and end-strobe decode.
// Revision : 1.0
// ============================================================================
module vtg_counter
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_adv,
    output logic [11:0] o_h_pos,
    output logic [11:0] o_v_pos,
    output logic        o_de,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_line_end,
    output logic        o_frame_end
);

    localparam logic [11:0] c_h_last   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] c_v_last   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] c_h_act    = 12'(H_ACTIVE);
    localparam logic [11:0] c_v_act    = 12'(V_ACTIVE);
    localparam logic [11:0] c_hs_begin = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_hs_stop  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_vs_begin = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_vs_stop  = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] r_h_pos;
    logic [11:0] r_v_pos;
    logic        w_h_last;
    logic        w_v_last;

    assign w_h_last = (r_h_pos == c_h_last);
    assign w_v_last = (r_v_pos == c_v_last);

    // Wrap compares are made on the current value so nothing ever counts past the last position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_pos <= '0;
            r_v_pos <= '0;
        end else if (i_adv) begin
            if (w_h_last) begin
                r_h_pos <= '0;
                r_v_pos <= w_v_last ? 12'd0 : r_v_pos + 12'd1;
            end else begin
                r_h_pos <= r_h_pos + 12'd1;
            end
        end
    end

    assign o_h_pos     = r_h_pos;
    assign o_v_pos     = r_v_pos;
    assign o_de        = (r_h_pos < c_h_act) && (r_v_pos < c_v_act);
    assign o_hs        = !((r_h_pos >= c_hs_begin) && (r_h_pos < c_hs_stop));
    assign o_vs        = !((r_v_pos >= c_vs_begin) && (r_v_pos < c_vs_stop));
    assign o_line_end  = i_adv && w_h_last;
    assign o_frame_end = o_line_end && w_v_last;

endmodule
`default_nettype wire

// File: rtl/ruler_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : ruler_pattern_gen
// Brief    : Synthetic 640x480 ruler image source with scrolling tick rows.
// Revision : 1.0
// ============================================================================
module ruler_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE    = c_h_active,
    parameter int H_FP        = c_h_fp,
    parameter int H_SYNC      = c_h_sync,
    parameter int H_BP        = c_h_bp,
    parameter int V_ACTIVE    = c_v_active,
    parameter int V_FP        = c_v_fp,
    parameter int V_SYNC      = c_v_sync,
    parameter int V_BP        = c_v_bp,
    parameter int RULER_X0    = 256,
    parameter int RULER_X1    = 276,
    parameter int TICK_PITCH  = 40,
    parameter int TICK_WIDTH  = 2,
    parameter int SCROLL_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        scroll_en,
    input  logic        scroll_dir,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        dilate,
    output logic        frame_start,
    output logic [11:0] scroll_offset
);

    localparam logic [11:0] c_x0       = 12'(RULER_X0);
    localparam logic [11:0] c_x1       = 12'(RULER_X1);
    localparam logic [11:0] c_pitch    = 12'(TICK_PITCH);
    localparam logic [11:0] c_pitch_m1 = 12'(TICK_PITCH - 1);
    localparam logic [11:0] c_tick_w   = 12'(TICK_WIDTH);
    localparam logic [11:0] c_step     = 12'(SCROLL_STEP);
    localparam logic [11:0] c_v_act    = 12'(V_ACTIVE);

    logic [0:0]  r_state;
    logic        w_run;
    logic [11:0] w_h_pos;
    logic [11:0] w_v_pos;
    logic        w_de;
    logic        w_hs;
    logic        w_vs;
    logic        w_line_end;
    logic        w_frame_end;
    logic [11:0] r_phase;
    logic [11:0] r_offset;
    logic [11:0] w_phase;
    logic [11:0] w_phase_next;
    logic [11:0] w_offset_next;
    logic [11:0] w_sum;
    logic        w_dark;

    assign w_run = (r_state == c_st_run);

    vtg_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_vtg (
        .clk         (clk),
        .rst         (rst),
        .i_adv       (w_run),
        .o_h_pos     (w_h_pos),
        .o_v_pos     (w_v_pos),
        .o_de        (w_de),
        .o_hs        (w_hs),
        .o_vs        (w_vs),
        .o_line_end  (w_line_end),
        .o_frame_end (w_frame_end)
    );

    // Line 0 takes the frame's offset directly; later lines use the running phase.
    assign w_phase      = (w_v_pos == 12'd0) ? r_offset : r_phase;
    assign w_phase_next = (w_phase == c_pitch_m1) ? 12'd0 : w_phase + 12'd1;
    assign w_dark       = w_de && (w_h_pos > c_x0) && (w_h_pos < c_x1) && (w_phase < c_tick_w);

    always_comb begin
        w_sum         = r_offset + c_step;
        w_offset_next = r_offset;
        if (!scroll_dir) begin
            w_offset_next = (w_sum >= c_pitch) ? w_sum - c_pitch : w_sum;
        end else begin
            w_offset_next = (r_offset < c_step) ? r_offset + c_pitch - c_step
                                                : r_offset - c_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !w_run) begin
            r_phase <= '0;
        end else if (w_line_end) begin
            r_phase <= w_phase_next;
        end
        if (rst) begin
            r_offset <= '0;
        end else if (w_frame_end && scroll_en) begin
            r_offset <= w_offset_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            scroll_offset <= '0;
        end else begin
            scroll_offset <= r_offset;
            case (r_state)
                c_st_idle: if (en) r_state <= c_st_run;
                c_st_run:  if (w_frame_end && !en) r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end

        if (rst || !w_run) begin
            hs          <= 1'b1;
            vs          <= 1'b1;
            de          <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            dilate      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hs          <= w_hs;
            vs          <= w_vs;
            de          <= w_de;
            h_cnt       <= w_de ? w_h_pos : 12'd0;
            v_cnt       <= (w_v_pos < c_v_act) ? w_v_pos : 12'd0;
            dilate      <= !w_dark;
            frame_start <= (w_h_pos == 12'd0) && (w_v_pos == 12'd0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ruler_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ruler_pattern_gen
// Brief    : Bench for ruler_pattern_gen: reduced-timing instance against a
//            frame model, plus a default-timing instance for line geometry.
// Revision : 1.0
// ============================================================================
module tb_ruler_pattern_gen;

    localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
    localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
    localparam int X0 = 10, X1 = 16, P = 8, TW = 2, ST = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, scroll_en, scroll_dir;
    logic        hs, vs, de, dilate, frame_start;
    logic [11:0] h_cnt, v_cnt, scroll_offset;

    logic        rst2, en2;
    logic        hs2, vs2, de2, dilate2, fs2;
    logic [11:0] h_cnt2, v_cnt2, off2;

    int tests = 0;
    int fails = 0;
    bit done2 = 1'b0;

    ruler_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .RULER_X0(X0), .RULER_X1(X1), .TICK_PITCH(P), .TICK_WIDTH(TW),
        .SCROLL_STEP(ST)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .scroll_en(scroll_en), .scroll_dir(scroll_dir),
        .hs(hs), .vs(vs), .de(de), .h_cnt(h_cnt), .v_cnt(v_cnt), .dilate(dilate),
        .frame_start(frame_start), .scroll_offset(scroll_offset)
    );

    ruler_pattern_gen dut_dflt (
        .clk(clk), .rst(rst2), .en(en2), .scroll_en(1'b0), .scroll_dir(1'b0),
        .hs(hs2), .vs(vs2), .de(de2), .h_cnt(h_cnt2), .v_cnt(v_cnt2), .dilate(dilate2),
        .frame_start(fs2), .scroll_offset(off2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: position index within the frame and the frame's offset.
    bit          m_run = 1'b0;
    int          m_pos = 0;
    int          m_off = 0;
    bit          chk_en = 1'b0;
    logic [63:0] exp_vec;

    function automatic logic [63:0] pack(input logic a_hs, input logic a_vs, input logic a_de,
                                         input logic [11:0] a_h, input logic [11:0] a_v,
                                         input logic a_dil, input logic a_fs, input logic [11:0] a_off);
        return {23'd0, a_hs, a_vs, a_de, a_h, a_v, a_dil, a_fs, a_off};
    endfunction

    always @(posedge clk) begin
        int h, v;
        logic e_de;
        if (rst) begin
            m_run = 1'b0; m_pos = 0; m_off = 0;
            exp_vec = pack(1, 1, 0, 0, 0, 1, 0, 0);
            chk_en = 1'b1;
        end else begin
            if (!m_run) begin
                exp_vec = pack(1, 1, 0, 0, 0, 1, 0, 12'(m_off));
            end else begin
                h = m_pos % HT;
                v = m_pos / HT;
                e_de = (h < HA) && (v < VA);
                exp_vec = pack(!(h >= HA + HFP && h < HA + HFP + HSY),
                               !(v >= VA + VFP && v < VA + VFP + VSY),
                               e_de,
                               e_de ? 12'(h) : 12'd0,
                               (v < VA) ? 12'(v) : 12'd0,
                               !(e_de && h > X0 && h < X1 && ((v + m_off) % P) < TW),
                               m_pos == 0,
                               12'(m_off));
            end
            if (!m_run) begin
                if (en) begin m_run = 1'b1; m_pos = 0; end
            end else if (m_pos == FRAME - 1) begin
                if (scroll_en) m_off = scroll_dir ? (m_off - ST + P) % P : (m_off + ST) % P;
                m_pos = 0;
                if (!en) m_run = 1'b0;
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("model", pack(hs, vs, de, h_cnt, v_cnt, dilate, frame_start, scroll_offset), exp_vec);
    end

    task automatic count_frame(input int n, output int n_dark, output int n_de,
                               output int n_vs, output int n_hs);
        n_dark = 0; n_de = 0; n_vs = 0; n_hs = 0;
        for (int i = 0; i < n; i++) begin
            if (!dilate) n_dark++;
            if (de) n_de++;
            if (!vs) n_vs++;
            if (!hs) n_hs++;
            @(negedge clk);
        end
    endtask

    initial begin : main
        int nd, nde, nvs, nhs;
        int exp_off [8] = '{0, 3, 6, 1, 4, 7, 2, 5};
        bit found;
        rst = 1'b1; en = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", pack(hs, vs, de, h_cnt, v_cnt, dilate, frame_start, scroll_offset),
              {23'd0, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 12'd0});

        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        check("fs_not_early", frame_start, 0);
        @(negedge clk);
        check("first_pixel", {frame_start, de, h_cnt, v_cnt}, {1'b1, 1'b1, 12'd0, 12'd0});

        count_frame(FRAME, nd, nde, nvs, nhs);
        check("dark_px_off0", nd, 40);
        check("de_per_frame", nde, VA * HA);
        check("vs_low_clks", nvs, VSY * HT);
        check("hs_low_clks", nhs, VT * HSY);
        check("fs_period", frame_start, 1);

        scroll_en = 1'b1; scroll_dir = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("scroll_up_off", scroll_offset, exp_off[k]);
            count_frame(FRAME, nd, nde, nvs, nhs);
            if (k == 1) check("dark_px_off3", nd, 35);
        end
        check("scroll_wrap_0", scroll_offset, 0);
        scroll_dir = 1'b1;
        count_frame(FRAME, nd, nde, nvs, nhs);
        check("scroll_down_0", scroll_offset, 5);
        scroll_en = 1'b0;
        count_frame(FRAME, nd, nde, nvs, nhs);
        check("scroll_hold", scroll_offset, 5);

        repeat (10 * HT) @(negedge clk);
        check("at_line10", {de, v_cnt, h_cnt}, {1'b1, 12'd10, 12'd0});
        en = 1'b0;
        count_frame(FRAME, nd, nde, nvs, nhs);
        check("stop_de_rest", nde, (VA - 10) * HA);
        check("stop_vs_seen", nvs, VSY * HT);
        check("stop_hs_rest", nhs, (VT - 10) * HSY);
        count_frame(300, nd, nde, nvs, nhs);
        check("idle_de", nde, 0);
        check("idle_hs", nhs, 0);

        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (de && h_cnt == 12'd20 && v_cnt == 12'd3) begin found = 1'b1; break; end
        end
        check("found_mid_line", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midline_reset", pack(hs, vs, de, h_cnt, v_cnt, dilate, frame_start, scroll_offset),
              {23'd0, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 12'd0});
        rst = 1'b0; en = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5000 && !done2; i++) @(negedge clk);
        check("dflt_done", done2, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Default 640x480 timing: line geometry measured from the first frame_start.
    initial begin : dflt
        int de_fall, hs_fall, hs_rise, de_rise;
        bit found;
        rst2 = 1'b1; en2 = 1'b1;
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fs2) begin found = 1'b1; break; end
        end
        check("dflt_fs", found, 1);
        de_fall = -1; hs_fall = -1; hs_rise = -1; de_rise = -1;
        for (int t = 0; t < 1000; t++) begin
            if (de_fall < 0 && !de2) de_fall = t;
            if (hs_fall < 0 && !hs2) hs_fall = t;
            if (hs_fall >= 0 && hs_rise < 0 && hs2) hs_rise = t;
            if (de_fall >= 0 && de_rise < 0 && de2) de_rise = t;
            @(negedge clk);
        end
        check("dflt_de_len", de_fall, 640);
        check("dflt_hs_fall", hs_fall, 656);
        check("dflt_hs_rise", hs_rise, 752);
        check("dflt_line_per", de_rise, 800);
        done2 = 1'b1;
    end

endmodule
`default_nettype wire
